// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and defaults for the MEM pipeline stage
package mem_stage_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int WORD_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int DEF_DEPTH = 64;
  localparam int DEF_WAIT_CYCLES = 4;
  localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;
endpackage

// File: rtl/data_mem_array.sv
// data_mem_array: word-addressed data memory, synchronous write, combinational read
module data_mem_array
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WORD_W-1:0]        wdata,
  output logic [WORD_W-1:0]        rdata
);
  logic [WORD_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/data_mem_stage.sv
// data_mem_stage: MIPS MEM stage with fixed-latency data memory and pipeline stall
module data_mem_stage
  import mem_stage_pkg::*;
#(
  parameter int          DEPTH       = DEF_DEPTH,
  parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  WB_EN_IN,
  input  logic                  MEM_R_EN_IN,
  input  logic                  MEM_W_EN_IN,
  input  logic [REG_ADDR_W-1:0] destIn,
  input  logic [WORD_W-1:0]     ALUResIn,
  input  logic [WORD_W-1:0]     STValIn,
  output logic                  WB_EN,
  output logic                  MEM_R_EN,
  output logic [REG_ADDR_W-1:0] dest,
  output logic [WORD_W-1:0]     ALURes,
  output logic [WORD_W-1:0]     memReadVal,
  output logic                  ready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);
  state_t state, nxt;
  logic [3:0] cnt;
  logic op_r, op_w, in_r, req, hit, commit, we;
  logic [AW-1:0] idx;
  logic [WORD_W-1:0] off, st_val, rdata;
  assign req = MEM_R_EN_IN | MEM_W_EN_IN;
  // unsigned wrap makes addresses below base land far out of range
  assign off = ALUResIn - BASE_ADDR;
  assign hit = off[31:2] < DEPTH_W;
  assign commit = state == BUSY && cnt == 4'd0;
  assign we = commit && op_w && in_r && rst_n;
  assign ready = (state == IDLE && !req) || state == DONE;
  assign WB_EN = WB_EN_IN & ready;
  assign MEM_R_EN = MEM_R_EN_IN;
  assign dest = destIn;
  assign ALURes = ALUResIn;
  always_comb
    nxt = state == IDLE ? (req ? BUSY : IDLE) :
          state == BUSY ? (cnt == 4'd0 ? DONE : BUSY) : IDLE;
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : nxt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      memReadVal <= '0;
    end else begin
      if (state == IDLE && req) begin
        cnt <= 4'(WAIT_CYCLES - 1);
        op_r <= MEM_R_EN_IN;
        op_w <= MEM_W_EN_IN;
        in_r <= hit;
        idx <= off[AW+1:2];
        st_val <= STValIn;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // read happens at the commit edge, so a paired store returns the old word
      if (commit && op_r) memReadVal <= in_r ? rdata : '0;
    end
  end
  data_mem_array #(.DEPTH(DEPTH)) u_mem (
    .clk(clk), .we(we), .addr(idx), .wdata(st_val), .rdata(rdata)
  );
endmodule

// File: doc/data_mem_stage.md
# data_mem_stage

Memory-access (MEM) stage of the five-stage MIPS pipeline. Sits between the EXE/MEM pipeline register and the MEM/WB pipeline register. It performs loads and stores against a word-addressed data memory with a fixed multi-cycle access latency, and holds `ready` low to freeze the pipeline while an access is in flight. It also forwards the write-back control, destination and ALU result downstream, gated so no duplicate write-back is issued during a stall.

## Interface
Parameters:
- `DEPTH`, 64: data memory size in 32-bit words.
- `WAIT_CYCLES`, 4: memory busy cycles per access; legal range is 1..15.
- `BASE_ADDR`, 1024: byte address mapped to word 0.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `WB_EN_IN` in 1: write-back enable from EXE/MEM.
- `MEM_R_EN_IN` in 1: load request.
- `MEM_W_EN_IN` in 1: store request.
- `destIn` in 5: destination register.
- `ALUResIn` in 32: effective byte address, or the ALU result for non-memory instructions.
- `STValIn` in 32: store data.
- `WB_EN` out 1: `WB_EN_IN & ready`.
- `MEM_R_EN` out 1: `MEM_R_EN_IN`, passed through.
- `dest` out 5: `destIn`, passed through.
- `ALURes` out 32: `ALUResIn`, passed through.
- `memReadVal` out 32: load data, registered.
- `ready` out 1: 1 means the pipeline may advance at the next edge; 0 means freeze PC, IF/ID, ID/EXE and EXE/MEM.

## Operation
- Word index = (`ALUResIn` − `BASE_ADDR`) >> 2. Bits [1:0] are ignored. Unsigned 32-bit subtraction, so addresses below base wrap and count as out of range.
- Out of range (index ≥ `DEPTH`): the store is dropped, the load returns 0, and the timing is unchanged.
- FSM states are IDLE, BUSY and DONE.
  - IDLE: if `MEM_R_EN_IN | MEM_W_EN_IN`, capture the op, index and `STValIn`, load the counter with `WAIT_CYCLES-1`, and go to BUSY. Otherwise stay in IDLE.
  - BUSY: decrement the counter. When the counter is 0, commit the captured store or latch the read word into `memReadVal`, then go to DONE.
  - DONE: go to IDLE unconditionally.
- `ready` = (IDLE & !(`MEM_R_EN_IN` | `MEM_W_EN_IN`)) | DONE. It is combinational from state and inputs.
- Load and store asserted together: the store is performed and `memReadVal` returns the pre-write contents.
- Inputs changing while in BUSY are ignored, because the captured copies are used.
- Non-memory instructions pass through in one cycle with `ready`=1. `memReadVal` holds its last value.

## Timing
- Reset (`rst_n`=0 at an edge): state=IDLE, counter=0, `memReadVal`=0. Any pending store is abandoned. Memory contents are not cleared.
- Reset asserted mid-BUSY: no commit occurs, and the block is back in IDLE on the next cycle.
- Access accepted in cycle t (IDLE): BUSY runs from t+1 to t+`WAIT_CYCLES`, and DONE is cycle t+`WAIT_CYCLES`+1.
  - `ready`=0 from t to t+`WAIT_CYCLES`. `ready`=1 in DONE.
  - Total MEM occupancy is `WAIT_CYCLES`+2 cycles.
- `memReadVal` is valid throughout DONE and is captured by MEM/WB at the DONE→IDLE edge.
- Store data is visible to a load accepted in the following IDLE cycle.
- Back-to-back accesses: the next op arrives at the edge leaving DONE. IDLE then accepts it, so there is no idle bubble.

## Structure
- Package `mem_stage_pkg`:
  - state enum `{IDLE, BUSY, DONE}`.
  - `WORD_W`=32, `REG_ADDR_W`=5.
  - default constants for `BASE_ADDR`, `DEPTH` and `WAIT_CYCLES`.
- One sub-module, `data_mem_array`, with parameter `DEPTH` and ports `clk`, `we`, `addr`, `wdata`, `rdata`.
  - synchronous write; combinational read.
  - no reset.
- The FSM, counter, address decode and output gating live in `data_mem_stage`.

## Test plan
- Store 0xDEADBEEF at 1028 with `WAIT_CYCLES`=4 → `ready`=0 for 5 cycles, then 1 for 1 cycle; a later load from 1028 gives `memReadVal`=0xDEADBEEF in DONE and `WB_EN` high only in DONE.
- Non-memory op with `WB_EN_IN`=1, `ALUResIn`=0x55 → `ready`=1 every cycle, `ALURes`=0x55, `WB_EN`=1, no stall.
- Load from 1024+4·`DEPTH` and from 1020 → returns 0 with normal latency; a store to those addresses leaves all words unchanged.
- Drop `rst_n` in the 2nd BUSY cycle of a store of 0x12345678 to 1032 → next cycle IDLE, `memReadVal`=0, and a later load from 1032 returns the old value.
- Back-to-back store 0xA to 1036 then load 1036 → the second access starts in the cycle after DONE; the load returns 0xA.
- Load and store both high at 1040 (old 0x1, new 0x2) → `memReadVal`=0x1, and a later load returns 0x2.
